// File: rtl/edisk_mapper.sv
// edisk_mapper: multi-channel E-disk page mapper; EDISK_WIDE_WINDOW_EN lets cfg bit 6 widen the window to 8000-FFFF
module edisk_mapper #(
    parameter int         CHANNELS  = 4,
    parameter logic [7:0] PORT_BASE = 8'h10,
    parameter int         PAGE_W    = $clog2(4*CHANNELS+1)
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              cpu_sync,
    input  logic [7:0]        cpu_dout,
    input  logic [15:0]       addr,
    input  logic              io_wr,
    input  logic              io_rd,
    output logic              io_sel,
    output logic [7:0]        dout,
    output logic [PAGE_W-1:0] ed_page,
    output logic              ed_active
);
    localparam int IDX_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;

    logic [7:0]          cfg_q [CHANNELS];
    logic [7:0]          status_q;
    logic                io_wr_q;
    logic [PAGE_W-1:0]   page_d;
    logic [7:0]          off;
    logic [IDX_W-1:0]    idx;
    logic                mem_acc;
    logic                stack;
    logic                win_base;
    logic [CHANNELS-1:0] win;
    logic [CHANNELS-1:0] stk_hit;
    logic [CHANNELS-1:0] win_hit;
    logic                unused_bits;

    assign off         = addr[7:0] - PORT_BASE;
    assign idx         = off[IDX_W-1:0];
    assign io_sel      = off < 8'(CHANNELS);
    assign dout        = (io_sel && io_rd) ? cfg_q[idx] : 8'hFF;
    assign mem_acc     = (status_q[7] | ~status_q[1]) & ~status_q[4] & ~status_q[6];
    assign stack       = status_q[2];
    assign win_base    = addr[15] & (addr[14] ^ addr[13]);
    assign unused_bits = ^{addr[12:8], status_q[5], status_q[3], status_q[0]};

    // Per-channel window decode and hit qualification
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
`ifdef EDISK_WIDE_WINDOW_EN
            win[k] = addr[15] & (cfg_q[k][6] | win_base);
`else
            win[k] = win_base;
`endif
            stk_hit[k] = cfg_q[k][4] & stack & mem_acc;
            win_hit[k] = cfg_q[k][5] & win[k] & mem_acc & ~stk_hit[k];
        end
    end

    // Priority select: walking downward lets the lowest channel win, and stack hits are applied last so they override windows
    always_comb begin
        page_d = '0;
        for (int k = CHANNELS-1; k >= 0; k--)
            if (win_hit[k]) page_d = PAGE_W'(4*k + int'(cfg_q[k][1:0]) + 1);
        for (int k = CHANNELS-1; k >= 0; k--)
            if (stk_hit[k]) page_d = PAGE_W'(4*k + int'(cfg_q[k][3:2]) + 1);
    end

    // Status latch, one config write per io_wr rising edge, registered page outputs
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < CHANNELS; k++) cfg_q[k] <= '0;
            status_q  <= '0;
            io_wr_q   <= 1'b0;
            ed_page   <= '0;
            ed_active <= 1'b0;
        end else begin
            io_wr_q <= io_wr;
            if (cpu_sync) status_q <= cpu_dout;
            if (io_wr && !io_wr_q && io_sel) cfg_q[idx] <= cpu_dout;
            ed_page   <= page_d;
            ed_active <= page_d != '0;
        end
    end
endmodule

// File: tb/tb_edisk_mapper.sv
// tb_edisk_mapper: directed checks of edisk_mapper at CHANNELS=4, PORT_BASE=0x10
module tb_edisk_mapper;
    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        cpu_sync;
    logic [7:0]  cpu_dout;
    logic [15:0] addr;
    logic        io_wr;
    logic        io_rd;
    logic        io_sel;
    logic [7:0]  dout;
    logic [4:0]  ed_page;
    logic        ed_active;
    int          n_chk = 0;
    int          n_pass = 0;

    edisk_mapper dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .cpu_sync(cpu_sync), .cpu_dout(cpu_dout),
        .addr(addr), .io_wr(io_wr), .io_rd(io_rd), .io_sel(io_sel), .dout(dout),
        .ed_page(ed_page), .ed_active(ed_active)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wr(input logic [7:0] port, input logic [7:0] d);
        addr = {8'h00, port};
        cpu_dout = d;
        io_wr = 1'b1;
        step();
        io_wr = 1'b0;
        step();
    endtask

    task automatic sync(input logic [7:0] st);
        cpu_sync = 1'b1;
        cpu_dout = st;
        step();
        cpu_sync = 1'b0;
        step();
    endtask

    task automatic rdchk(input string tag, input logic [7:0] port, input logic [7:0] exp);
        addr = {8'h00, port};
        io_rd = 1'b1;
        #1;
        chk(tag, {8'h00, dout}, {8'h00, exp});
        io_rd = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; cpu_sync = 1'b0; cpu_dout = 8'h00; addr = 16'h0000; io_wr = 1'b0; io_rd = 1'b0;
        #12;
        chk("rst_page", 16'(ed_page), 16'd0);
        chk("rst_active", 16'(ed_active), 16'd0);
        chk("rst_dout_nord", {8'h00, dout}, 16'h00FF);
        step();
        reset_n = 1'b1;
        step();
        // fresh state: no mapping
        addr = 16'hA000;
        sync(8'h82);
        chk("t1_page", 16'(ed_page), 16'd0);
        for (int p = 0; p < 4; p++) rdchk("t1_rd", 8'h10 + 8'(p), 8'h00);
        // channel 1 window bank 1
        wr(8'h11, 8'h21);
        addr = 16'hB000;
        sync(8'h82);
        chk("t2_page", 16'(ed_page), 16'd6);
        chk("t2_active", 16'(ed_active), 16'd1);
        addr = 16'h7000;
        step();
        chk("t2_outside", 16'(ed_page), 16'd0);
        chk("t2_inactive", 16'(ed_active), 16'd0);
        rdchk("t2_rd", 8'h11, 8'h21);
        // stack beats window, window channel 2
        wr(8'h11, 8'h00);
        wr(8'h10, 8'h10);
        wr(8'h12, 8'h27);
        addr = 16'hC000;
        sync(8'h86);
        chk("t3_stack", 16'(ed_page), 16'd1);
        sync(8'h82);
        chk("t3_win", 16'(ed_page), 16'd12);
        sync(8'h92);
        chk("t3_nomem", 16'(ed_page), 16'd0);
        wr(8'h11, 8'h25);
        addr = 16'hC000;
        sync(8'h82);
        chk("t3_win_low", 16'(ed_page), 16'd6);
        wr(8'h13, 8'h1C);
        addr = 16'hC000;
        sync(8'h86);
        chk("t3_stk_low", 16'(ed_page), 16'd1);
        wr(8'h10, 8'h00);
        addr = 16'hC000;
        step();
        chk("t3_stk_ch3", 16'(ed_page), 16'd16);
        // long io_wr pulse, out-of-range port, edge outside range
        for (int p = 0; p < 4; p++) wr(8'h10 + 8'(p), 8'h00);
        addr = 16'h0010;
        cpu_dout = 8'h05;
        io_wr = 1'b1;
        step();
        cpu_dout = 8'h0A;
        repeat (4) step();
        io_wr = 1'b0;
        step();
        rdchk("t4_long", 8'h10, 8'h05);
        addr = 16'h0014;
        #1;
        chk("t4_sel14", 16'(io_sel), 16'd0);
        addr = 16'h0013;
        #1;
        chk("t4_sel13", 16'(io_sel), 16'd1);
        wr(8'h14, 8'h55);
        rdchk("t4_rd14", 8'h14, 8'hFF);
        rdchk("t4_rd10", 8'h10, 8'h05);
        for (int p = 1; p < 4; p++) rdchk("t4_rdx", 8'h10 + 8'(p), 8'h00);
        addr = 16'h0010;
        #1;
        chk("t4_nord", {8'h00, dout}, 16'h00FF);
        addr = 16'h0020;
        cpu_dout = 8'h77;
        io_wr = 1'b1;
        step();
        addr = 16'h0013;
        repeat (2) step();
        io_wr = 1'b0;
        step();
        rdchk("t4_late", 8'h13, 8'h00);
        // window boundaries and wide bit
        wr(8'h10, 8'h20);
        addr = 16'hDFFF;
        sync(8'h82);
        chk("t5_dfff", 16'(ed_page), 16'd1);
        addr = 16'hE000;
        step();
        chk("t5_e000", 16'(ed_page), 16'd0);
        addr = 16'h9FFF;
        step();
        chk("t5_9fff", 16'(ed_page), 16'd0);
        addr = 16'hA000;
        step();
        chk("t5_a000", 16'(ed_page), 16'd1);
        wr(8'h10, 8'h60);
        addr = 16'h8100;
        step();
`ifdef EDISK_WIDE_WINDOW_EN
        chk("t5_wide", 16'(ed_page), 16'd1);
`else
        chk("t5_wide", 16'(ed_page), 16'd0);
`endif
        addr = 16'h7FFF;
        step();
        chk("t5_7fff", 16'(ed_page), 16'd0);
        rdchk("t5_rd60", 8'h10, 8'h60);
        // sync and write edge in the same cycle
        wr(8'h10, 8'h00);
        addr = 16'hA011;
        cpu_dout = 8'hA2;
        cpu_sync = 1'b1;
        io_wr = 1'b1;
        step();
        chk("t6_lat", 16'(ed_page), 16'd0);
        cpu_sync = 1'b0;
        io_wr = 1'b0;
        step();
        chk("t6_page", 16'(ed_page), 16'd7);
        chk("t6_active", 16'(ed_active), 16'd1);
        rdchk("t6_rd", 8'h11, 8'hA2);
        // asynchronous reset
        reset_n = 1'b0;
        #1;
        chk("t7_page", 16'(ed_page), 16'd0);
        chk("t7_active", 16'(ed_active), 16'd0);
        reset_n = 1'b1;
        for (int p = 0; p < 4; p++) rdchk("t7_rd", 8'h10 + 8'(p), 8'h00);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
